axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive m0 grants won while m1 waits before m1 is forced next; range 1..15.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 m0_araddr/m0_arlen/m0_arsize/m0_arburst  in  32/8/3/2  m0 (display scanout, high priority) AR payload.
REQ-005 m0_arvalid  in  1 / m0_arready  out  1  m0 AR handshake.
REQ-006 m0_rdata/m0_rresp/m0_rlast/m0_rvalid  out  32/2/1/1  m0 R channel; m0_rready  in  1.
REQ-007 m1_* (same signals, widths and directions as REQ-004..006)  m1 (general DMA, low priority) port.
REQ-008 s_araddr/s_arlen/s_arsize/s_arburst/s_arvalid  out  32/8/3/2/1  AR towards SoC memory; s_arready  in  1.
REQ-009 s_rdata/s_rresp/s_rlast/s_rvalid  in  32/2/1/1  R from memory; s_rready  out  1.
REQ-010 grant  out  2  one-hot owner of current burst (bit0=m0, bit1=m1); 2'b00 when idle.
REQ-011 busy  out  1  high in ADDR and DATA states.
REQ-012 rerr_sticky  out  1  set on any R beat handshaked with s_rresp != 2'b00.

Function
REQ-013 FSM states IDLE, ADDR, DATA; exactly one burst outstanding on s_ at any time.
REQ-014 IDLE: no request -> stay, grant=00; else latch grant and go to ADDR on next edge (one cycle arbitration latency).
REQ-015 Selection in IDLE: only one arvalid -> that master; both -> m0, unless starve_ctr == STARVE_LIMIT, then m1.
REQ-016 starve_ctr (4 bits): +1 when m0 granted while m1_arvalid high, saturating at STARVE_LIMIT; cleared when m1 granted; unchanged otherwise.
REQ-017 ADDR: s_ar* = granted master's AR payload (combinational mux by grant); s_arvalid = granted arvalid; granted arready = s_arready; other arready = 0.
REQ-018 ADDR -> DATA on the edge where s_arvalid && s_arready; otherwise hold ADDR indefinitely (no timeout).
REQ-019 DATA: granted r* = s_r*; s_rready = granted rready; non-granted rvalid = 0, rdata/rresp/rlast = 0.
REQ-020 DATA -> IDLE on the edge where s_rvalid && s_rready && s_rlast; grant clears to 00 in IDLE.
REQ-021 Outside DATA: s_rready = 0, m0_rvalid = m1_rvalid = 0; outside ADDR: s_arvalid = 0, m0_arready = m1_arready = 0.
REQ-022 No same-cycle re-grant: minimum one IDLE cycle between bursts (bus turnaround).
REQ-023 Payload passes through unregistered; arbiter adds no beat buffering; R throughput = 1 beat/cycle when rready high.
REQ-024 arlen not interpreted; burst end determined solely by s_rlast.
REQ-025 New requests arriving during ADDR/DATA wait; their arready stays 0.

Reset
REQ-026 On rst: state=IDLE, grant=00, busy=0, starve_ctr=0, rerr_sticky=0, all arready/rvalid/s_arvalid/s_rready = 0.
REQ-027 rst mid-burst aborts immediately; remaining s_ beats are not accepted (s_rready=0); memory-side recovery is system-level.
REQ-028 rerr_sticky cleared only by rst.

Verification
REQ-029 m1 alone, arlen=31, addr 0x1000 -> grant=10, s_araddr=0x1000, 32 beats forwarded to m1, back to IDLE after rlast, grant=00.
REQ-030 m0 and m1 assert arvalid same cycle, STARVE_LIMIT=4, m0 re-requests after every burst -> grant order m0,m0,m0,m0,m1,m0...
REQ-031 s_arready held low 10 cycles in ADDR -> state stays ADDR, s_arvalid steady high, payload stable, no R forwarding.
REQ-032 Granted rready toggled 1/0 each cycle over 8-beat burst -> s_rready mirrors it, 8 beats delivered in order, no loss/duplication.
REQ-033 rst asserted on beat 3 of 16 -> next cycle grant=00, busy=0, s_rready=0; fresh m0 request then granted normally.
REQ-034 Beat with s_rresp=2'b10 -> rerr_sticky=1 next cycle and stays 1 across later OKAY bursts until rst.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// AXI read-only bus bundle (AR + R channels) shared by both requesters and the
// memory side of the arbiter.
//
// Handshake rule for every channel: a transfer happens on the rising clk edge
// where valid and ready are both high; the source holds payload and valid
// steady until that edge, and ready may go up or down at any time.
interface axi_rd_if;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    // Side that issues read requests and consumes read data.
    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    // Side that accepts read requests and returns read data.
    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter: m0 (display scanout) has priority over m1
// (DMA), with a starvation counter that forces m1 through after STARVE_LIMIT
// consecutive m0 wins. One burst is outstanding on the memory side at a time;
// payload and data pass through combinationally with no buffering.
module axi_rd_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    axi_rd_if.slave    m0,
    axi_rd_if.slave    m1,
    axi_rd_if.master   s,
    output logic [1:0] grant,
    output logic       busy,
    output logic       rerr_sticky,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [1:0] grant_nxt;
    logic [3:0] starve_ctr, starve_nxt;
    logic       ar_hs;
    logic       r_hs;
    logic       in_addr;
    logic       in_data;

    assign in_addr   = (state == ADDR);
    assign in_data   = (state == DATA);
    assign ar_hs     = s.arvalid && s.arready;
    assign r_hs      = s.rvalid && s.rready;
    assign busy      = in_addr || in_data;
    assign state_dbg = state;

    // State, owner, starvation count and error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= 2'b00;
            starve_ctr  <= 4'd0;
            rerr_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            starve_ctr <= starve_nxt;
            if (r_hs && (s.rresp != 2'b00)) begin
                rerr_sticky <= 1'b1;
            end
        end
    end

    // Arbitration in IDLE and burst sequencing through ADDR and DATA.
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        starve_nxt = starve_ctr;
        case (state)
            IDLE: begin
                grant_nxt = 2'b00;
                if (m0.arvalid || m1.arvalid) begin
                    state_nxt = ADDR;
                    // m0 wins unless m1 has waited through LIMIT m0 grants.
                    if (m0.arvalid && (!m1.arvalid || (starve_ctr != LIMIT))) begin
                        grant_nxt = 2'b01;
                        if (m1.arvalid && (starve_ctr < LIMIT)) begin
                            starve_nxt = starve_ctr + 4'd1;
                        end
                    end else begin
                        grant_nxt  = 2'b10;
                        starve_nxt = 4'd0;
                    end
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                // Burst length comes only from s.rlast; arlen is never decoded.
                if (r_hs && s.rlast) begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

    // AR channel steering: payload muxed by owner, handshake live only in ADDR.
    always_comb begin
        s.araddr   = grant[1] ? m1.araddr  : m0.araddr;
        s.arlen    = grant[1] ? m1.arlen   : m0.arlen;
        s.arsize   = grant[1] ? m1.arsize  : m0.arsize;
        s.arburst  = grant[1] ? m1.arburst : m0.arburst;
        s.arvalid  = 1'b0;
        m0.arready = 1'b0;
        m1.arready = 1'b0;
        if (in_addr) begin
            s.arvalid  = (grant[0] && m0.arvalid) || (grant[1] && m1.arvalid);
            m0.arready = grant[0] && s.arready;
            m1.arready = grant[1] && s.arready;
        end
    end

    // R channel steering: only the owner sees data, and only in DATA.
    always_comb begin
        s.rready  = 1'b0;
        m0.rvalid = 1'b0;
        m0.rdata  = 32'd0;
        m0.rresp  = 2'b00;
        m0.rlast  = 1'b0;
        m1.rvalid = 1'b0;
        m1.rdata  = 32'd0;
        m1.rresp  = 2'b00;
        m1.rlast  = 1'b0;
        if (in_data) begin
            s.rready = (grant[0] && m0.rready) || (grant[1] && m1.rready);
            if (grant[0]) begin
                m0.rvalid = s.rvalid;
                m0.rdata  = s.rdata;
                m0.rresp  = s.rresp;
                m0.rlast  = s.rlast;
            end
            if (grant[1]) begin
                m1.rvalid = s.rvalid;
                m1.rdata  = s.rdata;
                m1.rresp  = s.rresp;
                m1.rlast  = s.rlast;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: single-master burst, starvation order,
// AR back-pressure, R back-pressure, mid-burst reset and sticky error.
module tb_axi_rd_arbiter;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_rd_if m0_bus ();
    axi_rd_if m1_bus ();
    axi_rd_if s_bus ();

    logic [1:0] grant;
    logic       busy;
    logic       rerr_sticky;
    logic [1:0] state_dbg;

    axi_rd_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .s           (s_bus),
        .grant       (grant),
        .busy        (busy),
        .rerr_sticky (rerr_sticky),
        .state_dbg   (state_dbg)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    // Scoreboard compare.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Bounded wait for the address phase.
    task automatic wait_addr(input string tag);
        int n;
        n = 0;
        while ((state_dbg !== ST_ADDR) && (n < 20)) begin
            tick();
            #1;
            n++;
        end
        check({tag, "_reach_addr"}, 32'(state_dbg), 32'(ST_ADDR));
    endtask

    // Check owner and address, then complete the AR handshake.
    task automatic addr_phase(input int who, input logic [31:0] exp_addr, input string tag);
        wait_addr(tag);
        check({tag, "_grant"}, 32'(grant), (who == 0) ? 32'd1 : 32'd2);
        check({tag, "_araddr"}, s_bus.araddr, exp_addr);
        s_bus.arready = 1'b1;
        #1;
        check({tag, "_arready_own"}, (who == 0) ? 32'(m0_bus.arready) : 32'(m1_bus.arready), 32'd1);
        check({tag, "_arready_other"}, (who == 0) ? 32'(m1_bus.arready) : 32'(m0_bus.arready), 32'd0);
        tick();
        s_bus.arready = 1'b0;
        #1;
        check({tag, "_in_data"}, 32'(state_dbg), 32'(ST_DATA));
    endtask

    // Memory returns nbeats at full rate; owner's rready held high.
    task automatic serve_beats(input int who, input int nbeats, input logic [31:0] base,
                               input int err_beat, input string tag);
        logic [31:0] got;
        logic        gv;
        for (int i = 0; i < nbeats; i++) exp_q.push_back(base + 32'(i));
        m0_bus.rready = 1'b1;
        m1_bus.rready = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            s_bus.rvalid = 1'b1;
            s_bus.rdata  = base + 32'(i);
            s_bus.rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            s_bus.rlast  = (i == nbeats - 1);
            #1;
            got = (who == 0) ? m0_bus.rdata  : m1_bus.rdata;
            gv  = (who == 0) ? m0_bus.rvalid : m1_bus.rvalid;
            check({tag, "_rvalid"}, 32'(gv), 32'd1);
            check({tag, "_rdata"}, got, exp_q.pop_front());
            tick();
        end
        s_bus.rvalid = 1'b0;
        s_bus.rlast  = 1'b0;
        s_bus.rresp  = 2'b00;
        #1;
        check({tag, "_back_idle"}, 32'(state_dbg), 32'(ST_IDLE));
        check({tag, "_grant_clear"}, 32'(grant), 32'd0);
    endtask

    // Guard against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int exp_who [6];
        logic rr;
        int idx;
        int rcv;
        int cyc;

        m0_bus.araddr = 32'd0; m0_bus.arlen = 8'd0; m0_bus.arsize = 3'd2;
        m0_bus.arburst = 2'b01; m0_bus.arvalid = 1'b0; m0_bus.rready = 1'b0;
        m1_bus.araddr = 32'd0; m1_bus.arlen = 8'd0; m1_bus.arsize = 3'd2;
        m1_bus.arburst = 2'b01; m1_bus.arvalid = 1'b0; m1_bus.rready = 1'b0;
        s_bus.arready = 1'b0; s_bus.rdata = 32'd0; s_bus.rresp = 2'b00;
        s_bus.rlast = 1'b0; s_bus.rvalid = 1'b0;

        // Reset state, with a request pending that reset must ignore.
        rst = 1'b1;
        tick();
        m0_bus.arvalid = 1'b1;
        repeat (3) tick();
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_rerr", 32'(rerr_sticky), 32'd0);
        check("rst_m0_arready", 32'(m0_bus.arready), 32'd0);
        check("rst_s_arvalid", 32'(s_bus.arvalid), 32'd0);
        check("rst_s_rready", 32'(s_bus.rready), 32'd0);
        m0_bus.arvalid = 1'b0;
        tick();
        rst = 1'b0;

        // m1 alone, 32-beat burst at 0x1000.
        tick();
        m1_bus.araddr  = 32'h0000_1000;
        m1_bus.arlen   = 8'd31;
        m1_bus.arvalid = 1'b1;
        #1;
        check("m1_arb_latency", 32'(grant), 32'd0);
        check("m1_no_early_arvalid", 32'(s_bus.arvalid), 32'd0);
        tick();
        #1;
        check("m1_arlen", 32'(s_bus.arlen), 32'd31);
        check("m1_busy", 32'(busy), 32'd1);
        check("m1_arready_wait", 32'(m1_bus.arready), 32'd0);
        addr_phase(1, 32'h0000_1000, "m1");
        m1_bus.arvalid = 1'b0;
        serve_beats(1, 32, 32'h5A00_0000, -1, "m1_burst");
        check("m1_busy_after", 32'(busy), 32'd0);

        // Both masters requesting continuously: m1 forced in after four m0 wins.
        exp_who = '{0, 0, 0, 0, 1, 0};
        m0_bus.araddr  = 32'h0000_A000;
        m1_bus.araddr  = 32'h0000_B000;
        m0_bus.arvalid = 1'b1;
        m1_bus.arvalid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            addr_phase(exp_who[k], (exp_who[k] == 1) ? 32'h0000_B000 : 32'h0000_A000, "starve");
            check("starve_wait_arready_m0", 32'(m0_bus.arready), 32'd0);
            check("starve_wait_arready_m1", 32'(m1_bus.arready), 32'd0);
            serve_beats(exp_who[k], 1, 32'h0000_0100 * 32'(k), -1, "starve_burst");
        end
        m0_bus.arvalid = 1'b0;
        m1_bus.arvalid = 1'b0;
        check("no_err_yet", 32'(rerr_sticky), 32'd0);

        // AR back-pressure for 10 cycles, R beats offered early must not leak.
        tick();
        m0_bus.araddr  = 32'h0000_C000;
        m0_bus.arlen   = 8'd7;
        m0_bus.arvalid = 1'b1;
        m0_bus.rready  = 1'b1;
        #1;
        wait_addr("bp");
        s_bus.rvalid = 1'b1;
        s_bus.rdata  = 32'hDEAD_BEEF;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("bp_state", 32'(state_dbg), 32'(ST_ADDR));
            check("bp_arvalid", 32'(s_bus.arvalid), 32'd1);
            check("bp_araddr", s_bus.araddr, 32'h0000_C000);
            check("bp_arlen", 32'(s_bus.arlen), 32'd7);
            check("bp_no_rvalid", 32'(m0_bus.rvalid), 32'd0);
            check("bp_no_rready", 32'(s_bus.rready), 32'd0);
            tick();
        end
        s_bus.arready = 1'b1;
        tick();
        s_bus.arready  = 1'b0;
        m0_bus.arvalid = 1'b0;

        // R back-pressure: owner rready toggles each cycle over 8 beats.
        for (int i = 0; i < 8; i++) exp_q.push_back(32'hC0DE_0000 + 32'(i));
        idx = 0;
        rcv = 0;
        cyc = 0;
        while ((idx < 8) && (cyc < 40)) begin
            rr = (cyc % 2 == 0);
            m0_bus.rready = rr;
            s_bus.rvalid  = 1'b1;
            s_bus.rdata   = 32'hC0DE_0000 + 32'(idx);
            s_bus.rlast   = (idx == 7);
            #1;
            check("rbp_rready_mirror", 32'(s_bus.rready), 32'(rr));
            check("rbp_rvalid", 32'(m0_bus.rvalid), 32'd1);
            if (rr) begin
                check("rbp_rdata", m0_bus.rdata, exp_q.pop_front());
                rcv++;
            end
            if (s_bus.rready) idx++;
            tick();
            cyc++;
        end
        s_bus.rvalid = 1'b0;
        s_bus.rlast  = 1'b0;
        #1;
        check("rbp_beats", 32'(rcv), 32'd8);
        check("rbp_back_idle", 32'(state_dbg), 32'(ST_IDLE));

        // SLVERR beat sets the sticky flag; a later OKAY burst leaves it set.
        m1_bus.araddr  = 32'h0000_D000;
        m1_bus.arvalid = 1'b1;
        addr_phase(1, 32'h0000_D000, "err");
        m1_bus.arvalid = 1'b0;
        serve_beats(1, 2, 32'h0E00_0000, 0, "err_burst");
        check("rerr_set", 32'(rerr_sticky), 32'd1);
        m0_bus.araddr  = 32'h0000_D100;
        m0_bus.arvalid = 1'b1;
        addr_phase(0, 32'h0000_D100, "ok");
        m0_bus.arvalid = 1'b0;
        serve_beats(0, 3, 32'h0F00_0000, -1, "ok_burst");
        check("rerr_stays", 32'(rerr_sticky), 32'd1);

        // Reset on beat 3 of 16 aborts the burst; a fresh request follows.
        m0_bus.araddr  = 32'h0000_E000;
        m0_bus.arlen   = 8'd15;
        m0_bus.arvalid = 1'b1;
        addr_phase(0, 32'h0000_E000, "abort");
        m0_bus.arvalid = 1'b0;
        m0_bus.rready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_bus.rvalid = 1'b1;
            s_bus.rdata  = 32'hAB00_0000 + 32'(i);
            s_bus.rlast  = 1'b0;
            #1;
            check("abort_rdata", m0_bus.rdata, 32'hAB00_0000 + 32'(i));
            if (i == 2) rst = 1'b1;
            tick();
        end
        #1;
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_s_rready", 32'(s_bus.rready), 32'd0);
        check("abort_m0_rvalid", 32'(m0_bus.rvalid), 32'd0);
        check("abort_rerr_clear", 32'(rerr_sticky), 32'd0);
        rst = 1'b0;
        tick();
        #1;
        check("abort_hold_idle", 32'(s_bus.rready), 32'd0);
        s_bus.rvalid   = 1'b0;
        m0_bus.araddr  = 32'h0000_F000;
        m0_bus.arvalid = 1'b1;
        #1;
        check("fresh_latency", 32'(grant), 32'd0);
        tick();
        #1;
        addr_phase(0, 32'h0000_F000, "fresh");
        m0_bus.arvalid = 1'b0;
        serve_beats(0, 1, 32'h1234_5678, -1, "fresh_burst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
